// File: rtl/psram_rd_capture_if.sv
// psram_rd_capture_if: read-data handoff from capture stage (master) to bus/cfg consumer (slave)
interface psram_rd_capture_if;
  logic [63:0] rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic        rd_short_o;
  logic        err_timeout_o;
  modport master(output rd_data_o, rd_valid_o, rd_short_o, err_timeout_o, input rd_ready_i);
  modport slave(input rd_data_o, rd_valid_o, rd_short_o, err_timeout_o, output rd_ready_i);
endinterface

// File: rtl/psram_rd_capture.sv
// psram_rd_capture: DDR DQS-edge read capture into a 64-bit MSB-first word; PSRAM_RDCAP_TIMEOUT_EN adds an edge timeout
module psram_rd_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int SKIP_EDGES  = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cap_start_i,
  input  logic [3:0]                cap_len_i,
  input  logic                      cap_win_i,
  input  logic                      psram_dqs_in_i,
  input  logic [7:0]                psram_io_in_i,
  output logic                      busy_o,
  psram_rd_capture_if.master        bus
);
  typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0]       dqs_s_q;
  logic [SYNC_STAGES-1:0][7:0]  io_s_q;
  logic [3:0]  len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic [1:0]  skip_q, skip_d;
  logic [63:0] data_q, data_d;
  logic        short_q, short_d, err_q, err_d;
  logic        dqs_edge, active, take, store, tmo_hit;
  assign dqs_edge = dqs_s_q[SYNC_STAGES-1] ^ dqs_s_q[SYNC_STAGES-2];
  assign active   = state_q == ARM || state_q == CAPT;
  assign take     = active && cap_win_i && dqs_edge;
  assign store    = take && skip_q == 2'(SKIP_EDGES);
`ifdef PSRAM_RDCAP_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  assign tmo_d   = (active && !dqs_edge) ? tmo_q + 16'd1 : 16'd0;
  assign tmo_hit = active && !dqs_edge && tmo_q == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_i)
    tmo_q <= rst_i ? 16'd0 : tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    skip_d     = skip_q;
    data_d     = data_q;
    short_d    = short_q;
    err_d      = err_q;
    if (state_q == IDLE && cap_start_i) begin
      state_d    = ARM;
      len_d      = (cap_len_i == 4'd0 || cap_len_i > 4'd8) ? 4'd8 : cap_len_i;
      byte_cnt_d = 4'd0;
      skip_d     = 2'd0;
      data_d     = 64'd0;
      short_d    = 1'b0;
      err_d      = 1'b0;
    end
    if (take && !store)
      skip_d = skip_q + 2'd1;
    if (store) begin
      data_d     = data_q | ({io_s_q[SYNC_STAGES-1], 56'd0} >> {byte_cnt_q, 3'd0});
      byte_cnt_d = byte_cnt_q + 4'd1;
    end
    if (state_q == ARM && cap_win_i)
      state_d = CAPT;
    if (state_q == CAPT && !cap_win_i) begin
      state_d = DONE;
      short_d = 1'b1;
    end else if (tmo_hit) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
    if (store && byte_cnt_q + 4'd1 == len_q)
      state_d = DONE;
    if (state_q == DONE && bus.rd_ready_i)
      state_d = IDLE;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q    <= IDLE;
      dqs_s_q    <= '0;
      io_s_q     <= '0;
      len_q      <= 4'd0;
      byte_cnt_q <= 4'd0;
      skip_q     <= 2'd0;
      data_q     <= 64'd0;
      short_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dqs_s_q    <= {dqs_s_q[SYNC_STAGES-2:0], psram_dqs_in_i};
      io_s_q     <= {io_s_q[SYNC_STAGES-2:0], psram_io_in_i};
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      skip_q     <= skip_d;
      data_q     <= data_d;
      short_q    <= short_d;
      err_q      <= err_d;
    end
  assign bus.rd_data_o     = data_q;
  assign bus.rd_valid_o    = state_q == DONE;
  assign bus.rd_short_o    = short_q;
  assign bus.err_timeout_o = err_q;
  assign busy_o            = state_q != IDLE;
endmodule
